// File: rtl/apb_write_master.sv
// apb_write_master: write side of the AXI-to-APB bridge.
// Takes one burst command, pops one FIFO word per beat, issues one APB write
// per beat and returns a single aggregated write response.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a command (cmd_ready=1)
// S_WAIT_DATA | waiting for the data FIFO; pops the head when non-empty
// S_SETUP     | APB setup phase (psel=1, penable=0)
// S_ACCESS    | APB access phase, held until pready
// S_RESP      | aggregated response offered until resp_ready
module apb_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rden,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_WIDTH-1:0]   resp_id,
  output logic [1:0]            resp_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;

  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  wrap_ok;
  logic                  last_beat;

  // Next beat address; WRAP with an unsupported length degrades to INCR.
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    wrap_ok   = (burst_q == 2'b10) &&
                ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
    last_beat = (beat_q == len_q);
    if (burst_q == 2'b00) begin
      addr_next = addr_q;
    end else if (wrap_ok) begin
      addr_next = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
    end else begin
      addr_next = addr_q + incr;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (cmd_valid) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (!fifo_empty) state_d = S_SETUP;
      S_SETUP:     state_d = S_ACCESS;
      S_ACCESS:    if (pready) state_d = last_beat ? S_RESP : S_WAIT_DATA;
      S_RESP:      if (resp_ready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; APB address/data come from holding registers.
  always_comb begin
    cmd_ready  = (state_q == S_IDLE);
    fifo_rden  = (state_q == S_WAIT_DATA) && !fifo_empty;
    psel       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    penable    = (state_q == S_ACCESS);
    pwrite     = psel;
    paddr      = paddr_q;
    pwdata     = pwdata_q;
    resp_valid = (state_q == S_RESP);
    resp_id    = id_q;
    resp_code  = ((state_q == S_RESP) && err_q) ? 2'b10 : 2'b00;
  end

  // Command latch, beat/address bookkeeping, error aggregation, APB holding regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            id_q    <= cmd_id;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            size_q  <= cmd_size;
            burst_q <= cmd_burst;
            beat_q  <= '0;
            err_q   <= 1'b0;
          end
        end
        S_WAIT_DATA: begin
          if (!fifo_empty) begin
            pwdata_q <= fifo_rdata;
            paddr_q  <= addr_q;
          end
        end
        S_ACCESS: begin
          if (pready) begin
            err_q <= err_q | pslverr;
            if (!last_beat) begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
